dc_click_gen: RTL and testbench

DC_CLICK_GEN -- requirements
Module: dc_click_gen

---
 rtl/dc_pkg.sv | 20 ++
 rtl/dc_period_cnt.sv | 38 +++
 rtl/dc_click_gen.sv | 150 +++++++++++++++
 tb/tb_dc_click_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// ============================================================
// Module   : dc_pkg
// Brief    : Shared state encoding and default width for the DC click path.
// Revision : 1.0
// ============================================================
`default_nettype none

package dc_pkg;

  localparam int cDefCntW = 16;

  typedef enum logic [1:0] {
    sIdle = 2'd0,
    sAct  = 2'd1,
    sGap  = 2'd2
  } dcState_t;

endpackage

`default_nettype wire

// File: rtl/dc_period_cnt.sv
// ============================================================
// Module   : dc_period_cnt
// Brief    : Loadable half-period down-counter with terminal pulse.
// Revision : 1.0
// ============================================================
`default_nettype none

module dc_period_cnt
  import dc_pkg::*;
#(
  parameter int CNT_W = cDefCntW
) (
  input  logic             wClk_i,
  input  logic             wReset_i,
  input  logic             wEn_i,
  input  logic             wLoad_i,
  input  logic [CNT_W-1:0] wLoadVal_i,
  output logic             wTerm_o
);

  logic [CNT_W-1:0] rCnt;

  always_ff @(posedge wClk_i or negedge wReset_i) begin
    if (!wReset_i) begin
      rCnt <= '0;
    end else if (wLoad_i) begin
      rCnt <= wLoadVal_i;
    end else if (rCnt != '0) begin
      rCnt <= rCnt - 1'b1;
    end
  end

  // A phase loaded with L-1 reaches zero on its L-th cycle.
  assign wTerm_o = wEn_i && (rCnt == '0);

endmodule

`default_nettype wire

// File: rtl/dc_click_gen.sv
// ============================================================
// Module   : dc_click_gen
// Brief    : Emits a train of N clicks, each D cycles active then D idle.
// Revision : 1.0
// ============================================================
`default_nettype none

module dc_click_gen
  import dc_pkg::*;
#(
  parameter int CNT_W = cDefCntW
) (
  input  logic             wClk_i,
  input  logic             wReset_i,
  input  logic             wTrig_i,
  input  logic [CNT_W-1:0] wStep_i,
  input  logic [CNT_W-1:0] wDelay_i,
  input  logic             wHlvl_i,
  input  logic             wAbort_i,
  output logic             rClick_o,
  output logic             rBusy_o,
  output logic             rDone_o,
  output logic [CNT_W-1:0] rCount_o
);

  dcState_t         rState, wStateNxt;
  logic [CNT_W-1:0] rStep, wStepNxt;
  logic [CNT_W-1:0] rDelay, wDelayNxt;
  logic             rLevel, wLevelNxt;
  logic             wClickNxt, wBusyNxt, wDoneNxt;
  logic [CNT_W-1:0] wCountNxt;
  logic             wLoad;
  logic [CNT_W-1:0] wLoadVal;
  logic             wTerm;

  // A zero delay behaves as one cycle per phase.
  function automatic logic [CNT_W-1:0] phaseLoad(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  dc_period_cnt #(
    .CNT_W (CNT_W)
  ) uPeriod (
    .wClk_i     (wClk_i),
    .wReset_i   (wReset_i),
    .wEn_i      (rState != sIdle),
    .wLoad_i    (wLoad),
    .wLoadVal_i (wLoadVal),
    .wTerm_o    (wTerm)
  );

  always_ff @(posedge wClk_i or negedge wReset_i) begin
    if (!wReset_i) begin
      rState   <= sIdle;
      rStep    <= '0;
      rDelay   <= '0;
      rLevel   <= 1'b0;
      rClick_o <= 1'b0;
      rBusy_o  <= 1'b0;
      rDone_o  <= 1'b0;
      rCount_o <= '0;
    end else begin
      rState   <= wStateNxt;
      rStep    <= wStepNxt;
      rDelay   <= wDelayNxt;
      rLevel   <= wLevelNxt;
      rClick_o <= wClickNxt;
      rBusy_o  <= wBusyNxt;
      rDone_o  <= wDoneNxt;
      rCount_o <= wCountNxt;
    end
  end

  always_comb begin
    wStateNxt = rState;
    wStepNxt  = rStep;
    wDelayNxt = rDelay;
    wLevelNxt = rLevel;
    wClickNxt = rClick_o;
    wBusyNxt  = rBusy_o;
    wDoneNxt  = 1'b0;
    wCountNxt = rCount_o;
    wLoad     = 1'b0;
    wLoadVal  = phaseLoad(rDelay);

    unique case (rState)
      sIdle: begin
        wClickNxt = rLevel;
        wBusyNxt  = 1'b0;
        if (wTrig_i && !wAbort_i) begin
          wCountNxt = '0;
          if (wStep_i == '0) begin
            // Empty train: report completion, leave the line untouched.
            wDoneNxt = 1'b1;
          end else begin
            wStepNxt  = wStep_i;
            wDelayNxt = wDelay_i;
            wLevelNxt = wHlvl_i;
            wStateNxt = sAct;
            wClickNxt = ~wHlvl_i;
            wBusyNxt  = 1'b1;
            wLoad     = 1'b1;
            wLoadVal  = phaseLoad(wDelay_i);
          end
        end
      end

      sAct: begin
        if (wAbort_i) begin
          wStateNxt = sIdle;
          wClickNxt = rLevel;
          wBusyNxt  = 1'b0;
        end else if (wTerm) begin
          wCountNxt = rCount_o + 1'b1;
          wStateNxt = sGap;
          wClickNxt = rLevel;
          wLoad     = 1'b1;
        end
      end

      sGap: begin
        if (wAbort_i) begin
          wStateNxt = sIdle;
          wClickNxt = rLevel;
          wBusyNxt  = 1'b0;
        end else if (wTerm) begin
          if (rCount_o < rStep) begin
            wStateNxt = sAct;
            wClickNxt = ~rLevel;
            wLoad     = 1'b1;
          end else begin
            wStateNxt = sIdle;
            wClickNxt = rLevel;
            wBusyNxt  = 1'b0;
            wDoneNxt  = 1'b1;
          end
        end
      end

      default: begin
        wStateNxt = sIdle;
        wClickNxt = rLevel;
        wBusyNxt  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dc_click_gen.sv
// ============================================================
// Module   : tb_dc_click_gen
// Brief    : Directed and randomized click-train checks against a waveform model.
// Revision : 1.0
// ============================================================
`default_nettype none

module tb_dc_click_gen;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstN;
  logic         trig;
  logic [W-1:0] step;
  logic [W-1:0] delay;
  logic         hlvl;
  logic         abort;
  logic         click;
  logic         busy;
  logic         done;
  logic [W-1:0] count;

  int checks = 0;
  int failures = 0;

  // Model state visible while idle: line level and clicks of the last train.
  logic         mLevel;
  logic [W-1:0] mCount;

  always #5 clk = ~clk;

  dc_click_gen #(
    .CNT_W (W)
  ) dut (
    .wClk_i   (clk),
    .wReset_i (rstN),
    .wTrig_i  (trig),
    .wStep_i  (step),
    .wDelay_i (delay),
    .wHlvl_i  (hlvl),
    .wAbort_i (abort),
    .rClick_o (click),
    .rBusy_o  (busy),
    .rDone_o  (done),
    .rCount_o (count)
  );

  task automatic chk(input string tag, input logic [W+2:0] obs, input logic [W+2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed{click,busy,done,count}=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCheck(input string tag);
    chk(tag, {click, busy, done, count}, {mLevel, 1'b0, 1'b0, mCount});
  endtask

  // Trigger in the current cycle T and check every cycle up to completion.
  // Cycle T+k lies in half-period ph=(k-1)/L; even ph are active, and the
  // count shows the clicks whose active half has ended.
  task automatic runTrain(input string tag, input int n, input int d, input logic lvl,
                          input int abortK, input int extraK);
    int           L;
    int           total;
    int           ph;
    logic         eClick;
    logic [W-1:0] eCnt;
    L     = (d == 0) ? 1 : d;
    total = 2 * n * L;
    trig  = 1'b1;
    step  = W'(n);
    delay = W'(d);
    hlvl  = lvl;
    abort = 1'b0;
    tick();
    trig  = 1'b0;
    step  = W'($urandom);
    delay = W'($urandom);
    hlvl  = 1'($urandom);
    if (n == 0) begin
      mCount = '0;
      chk({tag, "_zero"}, {click, busy, done, count}, {mLevel, 1'b0, 1'b1, mCount});
      return;
    end
    mLevel = lvl;
    mCount = '0;
    for (int k = 1; k <= total + 1; k++) begin
      ph = (k - 1) / L;
      if (k == total + 1) begin
        mCount = W'(n);
        chk({tag, "_done"}, {click, busy, done, count}, {lvl, 1'b0, 1'b1, mCount});
        break;
      end
      eClick = (ph % 2 == 0) ? ~lvl : lvl;
      eCnt   = W'((ph + 1) / 2);
      chk({tag, "_run"}, {click, busy, done, count}, {eClick, 1'b1, 1'b0, eCnt});
      if (k == extraK) begin
        trig = 1'b1;
        step = W'($urandom_range(1, 15));
        hlvl = ~lvl;
      end
      if (k == abortK) begin
        abort = 1'b1;
        tick();
        abort  = 1'b0;
        trig   = 1'b0;
        mCount = eCnt;
        idleCheck({tag, "_abort"});
        return;
      end
      tick();
      trig = 1'b0;
    end
  endtask

  initial begin
    int n;
    int d;
    int tot;
    int ab;
    int ex;
    logic lv;

    rstN  = 1'b0;
    trig  = 1'b0;
    abort = 1'b0;
    step  = '0;
    delay = '0;
    hlvl  = 1'b0;
    mLevel = 1'b0;
    mCount = '0;

    #2;
    chk("reset_async", {click, busy, done, count}, '0);
    tick();
    tick();
    chk("reset_held", {click, busy, done, count}, '0);
    rstN = 1'b1;
    tick();
    idleCheck("idle_after_reset");

    runTrain("s3d4", 3, 4, 1'b0, 0, 0);
    runTrain("s2d0", 2, 0, 1'b1, 0, 0);
    runTrain("s0", 0, 3, mLevel, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      idleCheck("s0_quiet");
    end
    runTrain("s5_ignore_trig", 5, 3, 1'b0, 0, 7);
    runTrain("s4_abort", 4, 2, 1'b1, 6, 0);
    runTrain("after_abort", 1, 1, 1'b0, 0, 0);
    runTrain("back_to_back", 2, 2, 1'b1, 0, 0);

    // Trigger and abort together while idle: the trigger must be dropped.
    trig  = 1'b1;
    abort = 1'b1;
    step  = 4'd3;
    delay = 4'd1;
    hlvl  = ~mLevel;
    tick();
    trig  = 1'b0;
    abort = 1'b0;
    idleCheck("abort_beats_trig");
    tick();
    idleCheck("abort_beats_trig_2");

    runTrain("max_step", 15, 1, 1'b0, 0, 0);

    // Reset in the middle of an active phase.
    trig  = 1'b1;
    step  = 4'd3;
    delay = 4'd5;
    hlvl  = 1'b0;
    tick();
    trig = 1'b0;
    chk("rst_pre_act", {click, busy, done, count}, {1'b1, 1'b1, 1'b0, 4'd0});
    tick();
    rstN = 1'b0;
    #2;
    mLevel = 1'b0;
    mCount = '0;
    chk("rst_mid_async", {click, busy, done, count}, '0);
    tick();
    chk("rst_mid_c1", {click, busy, done, count}, '0);
    tick();
    chk("rst_mid_c2", {click, busy, done, count}, '0);
    rstN = 1'b1;
    runTrain("post_reset", 2, 1, 1'b1, 0, 0);

    for (int it = 0; it < 14; it++) begin
      n  = $urandom_range(0, 6);
      d  = $urandom_range(0, 4);
      lv = 1'($urandom_range(0, 1));
      if (n == 0) lv = mLevel;
      tot = 2 * n * ((d == 0) ? 1 : d);
      ab  = 0;
      ex  = 0;
      if (n > 0) begin
        if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, tot);
        ex = $urandom_range(1, tot);
      end
      runTrain("rand", n, d, lv, ab, ex);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        idleCheck("rand_gap");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
